draw_headstone: RTL and testbench

Reads the 16×32 headstone bitmap ROM and overlays a headstone on the VGA stream at the spot where a pedestrian was hit. It sits in the per-pixel draw chain between the background/car drawers and the VGA output. It drives the ROM row address, picks the column bit, and passes all timing signals through with a matched delay. A per-headstone lifetime FSM, counted in frames, shows the headstone, blinks it near the end of its life, then removes it.

---
 rtl/death_race_pkg.sv | 16 +
 rtl/headstone_life_ctl.sv | 141 ++++++++++++++
 rtl/draw_headstone.sv | 144 ++++++++++++++
 tb/tb_draw_headstone.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/death_race_pkg.sv
// Shared definitions for the death-race video pipeline.
// Provides the headstone bitmap geometry, the VGA coordinate width and the
// headstone lifetime FSM state encoding.
package death_race_pkg;

  localparam int HEADSTONE_W = 16;
  localparam int HEADSTONE_H = 32;
  localparam int COORD_W     = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLINK = 2'd2
  } headstone_state_e;

endpackage

// File: rtl/headstone_life_ctl.sv
// Headstone lifetime controller.
// Detects the frame tick (rising edge of vblnk_in), double-buffers spawn
// requests so a new position only takes effect inside vertical blanking, and
// runs the IDLE/SHOW/BLINK lifetime FSM counted in frames.
// Ports:
//   pclk, rst        pixel clock, asynchronous active-high reset
//   vblnk_in         vertical blanking; its rising edge is the frame tick
//   spawn            one-cycle request, samples spawn_x/spawn_y
//   xpos, ypos       top-left corner of the live headstone
//   visible          headstone pixels should be drawn this frame
//   active           FSM is not IDLE
module headstone_life_ctl
  import death_race_pkg::*;
#(
  parameter int LIFE_FRAMES  = 600,
  parameter int BLINK_FRAMES = 120,
  parameter int BLINK_PERIOD = 8
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               vblnk_in,
  input  logic               spawn,
  input  logic [COORD_W-1:0] spawn_x,
  input  logic [COORD_W-1:0] spawn_y,
  output logic [COORD_W-1:0] xpos,
  output logic [COORD_W-1:0] ypos,
  output logic               visible,
  output logic               active
);

  localparam int FW = $clog2(LIFE_FRAMES + 1);
  localparam int BW = $clog2(BLINK_PERIOD + 1);
  localparam logic [FW-1:0] LIFE_LOAD  = FW'(LIFE_FRAMES);
  localparam logic [FW-1:0] BLINK_AT   = FW'(BLINK_FRAMES);
  localparam logic [BW-1:0] PERIOD_END = BW'(BLINK_PERIOD);

  headstone_state_e   state, state_nxt;
  logic [FW-1:0]      frames_left, frames_nxt, frames_dec;
  logic [BW-1:0]      blink_cnt, bcnt_nxt, bcnt_inc;
  logic               blink_phase, bphase_nxt;
  logic [COORD_W-1:0] pend_x, pend_x_nxt, pend_y, pend_y_nxt;
  logic               pend_valid, pend_valid_nxt;
  logic [COORD_W-1:0] xpos_nxt, ypos_nxt;
  logic               vblnk_q;
  logic               tick;

  assign tick = vblnk_in & ~vblnk_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      frames_left <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      pend_x      <= '0;
      pend_y      <= '0;
      pend_valid  <= 1'b0;
      xpos        <= '0;
      ypos        <= '0;
      vblnk_q     <= 1'b0;
    end else begin
      state       <= state_nxt;
      frames_left <= frames_nxt;
      blink_cnt   <= bcnt_nxt;
      blink_phase <= bphase_nxt;
      pend_x      <= pend_x_nxt;
      pend_y      <= pend_y_nxt;
      pend_valid  <= pend_valid_nxt;
      xpos        <= xpos_nxt;
      ypos        <= ypos_nxt;
      vblnk_q     <= vblnk_in;
    end
  end

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt      = state;
    frames_nxt     = frames_left;
    bcnt_nxt       = blink_cnt;
    bphase_nxt     = blink_phase;
    pend_x_nxt     = pend_x;
    pend_y_nxt     = pend_y;
    pend_valid_nxt = pend_valid;
    xpos_nxt       = xpos;
    ypos_nxt       = ypos;
    frames_dec     = frames_left - FW'(1);
    bcnt_inc       = blink_cnt + BW'(1);

    if (tick) begin
      if (pend_valid) begin
        // A pending request overrides whatever the FSM was doing.
        xpos_nxt       = pend_x;
        ypos_nxt       = pend_y;
        pend_valid_nxt = 1'b0;
        state_nxt      = SHOW;
        frames_nxt     = LIFE_LOAD;
        bcnt_nxt       = '0;
        bphase_nxt     = 1'b0;
      end else begin
        unique case (state)
          SHOW: begin
            frames_nxt = frames_dec;
            if (frames_dec == '0) begin
              state_nxt = IDLE;
            end else if (frames_dec == BLINK_AT) begin
              state_nxt  = BLINK;
              bcnt_nxt   = '0;
              bphase_nxt = 1'b0;
            end
          end
          BLINK: begin
            frames_nxt = frames_dec;
            if (bcnt_inc == PERIOD_END) begin
              bcnt_nxt   = '0;
              bphase_nxt = ~blink_phase;
            end else begin
              bcnt_nxt = bcnt_inc;
            end
            if (frames_dec == '0) state_nxt = IDLE;
          end
          default: ;
        endcase
      end
    end

    // Applied after the tick logic: a spawn in the tick cycle is held for
    // the following tick, while the tick consumed the older request.
    if (spawn) begin
      pend_x_nxt     = spawn_x;
      pend_y_nxt     = spawn_y;
      pend_valid_nxt = 1'b1;
    end
  end

  assign visible = (state == SHOW) | ((state == BLINK) & ~blink_phase);
  assign active  = (state != IDLE);

endmodule

// File: rtl/draw_headstone.sv
// Headstone overlay for the per-pixel VGA draw chain.
// Two-stage pipeline: stage 1 performs the window test and drives the
// external bitmap ROM row address; stage 2 picks the column bit from the
// combinational ROM data and composites the colour. All timing signals are
// delayed by the same two cycles so they stay aligned with rgb_out.
// Ports:
//   pclk, rst                     pixel clock, asynchronous active-high reset
//   hcount/vcount/hsync/vsync/
//   hblnk/vblnk/rgb _in            upstream pixel stream
//   spawn, spawn_x, spawn_y        request a headstone at a top-left corner
//   rom_addr / rom_pixels          bitmap ROM row address / row data (bit 15 leftmost)
//   *_out                          pixel stream delayed two cycles
//   active                         a headstone is alive
module draw_headstone
  import death_race_pkg::*;
#(
  parameter logic [11:0] COLOR        = 12'hccc,
  parameter int          LIFE_FRAMES  = 600,
  parameter int          BLINK_FRAMES = 120,
  parameter int          BLINK_PERIOD = 8
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic [COORD_W-1:0] hcount_in,
  input  logic [COORD_W-1:0] vcount_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               hblnk_in,
  input  logic               vblnk_in,
  input  logic [11:0]        rgb_in,
  input  logic               spawn,
  input  logic [COORD_W-1:0] spawn_x,
  input  logic [COORD_W-1:0] spawn_y,
  output logic [4:0]         rom_addr,
  input  logic [15:0]        rom_pixels,
  output logic [COORD_W-1:0] hcount_out,
  output logic [COORD_W-1:0] vcount_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               hblnk_out,
  output logic               vblnk_out,
  output logic [11:0]        rgb_out,
  output logic               active
);

  logic [COORD_W-1:0] xpos, ypos;
  logic               visible;

  headstone_life_ctl #(
    .LIFE_FRAMES  (LIFE_FRAMES),
    .BLINK_FRAMES (BLINK_FRAMES),
    .BLINK_PERIOD (BLINK_PERIOD)
  ) u_life (
    .pclk     (pclk),
    .rst      (rst),
    .vblnk_in (vblnk_in),
    .spawn    (spawn),
    .spawn_x  (spawn_x),
    .spawn_y  (spawn_y),
    .xpos     (xpos),
    .ypos     (ypos),
    .visible  (visible),
    .active   (active)
  );

  // One extra bit keeps the subtraction unsigned without wrap: a pixel left
  // of or above the corner yields a value >= 2048, which fails the compare.
  logic [COORD_W:0] dx, dy;
  logic             in_win;

  assign dx     = {1'b0, hcount_in} - {1'b0, xpos};
  assign dy     = {1'b0, vcount_in} - {1'b0, ypos};
  assign in_win = (dx < (COORD_W+1)'(HEADSTONE_W)) && (dy < (COORD_W+1)'(HEADSTONE_H));

  // Stage 1
  logic               in_win_d, visible_d;
  logic [3:0]         col_d;
  logic [COORD_W-1:0] hcount_d, vcount_d;
  logic               hsync_d, vsync_d, hblnk_d, vblnk_d;
  logic [11:0]        rgb_d;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      in_win_d  <= 1'b0;
      visible_d <= 1'b0;
      col_d     <= '0;
      rom_addr  <= '0;
      hcount_d  <= '0;
      vcount_d  <= '0;
      hsync_d   <= 1'b0;
      vsync_d   <= 1'b0;
      hblnk_d   <= 1'b0;
      vblnk_d   <= 1'b0;
      rgb_d     <= '0;
    end else begin
      in_win_d  <= in_win;
      visible_d <= visible;
      col_d     <= dx[3:0];
      rom_addr  <= dy[4:0];
      hcount_d  <= hcount_in;
      vcount_d  <= vcount_in;
      hsync_d   <= hsync_in;
      vsync_d   <= vsync_in;
      hblnk_d   <= hblnk_in;
      vblnk_d   <= vblnk_in;
      rgb_d     <= rgb_in;
    end
  end

  // Bit 15 is the leftmost pixel, so column c maps to bit 15-c, which for a
  // 4-bit column is simply its bitwise inverse.
  logic        pix_on;
  logic [11:0] rgb_nxt;

  assign pix_on = in_win_d & visible_d & rom_pixels[~col_d];

  always_comb begin
    rgb_nxt = rgb_d;
    if (hblnk_d | vblnk_d) rgb_nxt = 12'h000;
    else if (pix_on)       rgb_nxt = COLOR;
  end

  // Stage 2
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      rgb_out    <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
    end else begin
      rgb_out    <= rgb_nxt;
      hcount_out <= hcount_d;
      vcount_out <= vcount_d;
      hsync_out  <= hsync_d;
      vsync_out  <= vsync_d;
      hblnk_out  <= hblnk_d;
      vblnk_out  <= vblnk_d;
    end
  end

endmodule

// File: tb/tb_draw_headstone.sv
// Self-checking bench for draw_headstone: directed vector tables, lifetime,
// spawn-ordering and reset sequences, then randomized pixels and spawns
// checked against a frame-level reference model.
module tb_draw_headstone;

  localparam logic [11:0] COLOR = 12'hccc;
  localparam int LIFE   = 10;
  localparam int BLINK  = 4;
  localparam int PERIOD = 2;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic        spawn = 1'b0;
  logic [10:0] spawn_x = '0, spawn_y = '0;
  logic [4:0]  rom_addr;
  logic [15:0] rom_pixels;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        active;

  draw_headstone #(
    .COLOR (COLOR), .LIFE_FRAMES (LIFE), .BLINK_FRAMES (BLINK), .BLINK_PERIOD (PERIOD)
  ) dut (
    .pclk (pclk), .rst (rst),
    .hcount_in (hcount_in), .vcount_in (vcount_in),
    .hsync_in (hsync_in), .vsync_in (vsync_in), .hblnk_in (hblnk_in), .vblnk_in (vblnk_in),
    .rgb_in (rgb_in), .spawn (spawn), .spawn_x (spawn_x), .spawn_y (spawn_y),
    .rom_addr (rom_addr), .rom_pixels (rom_pixels),
    .hcount_out (hcount_out), .vcount_out (vcount_out),
    .hsync_out (hsync_out), .vsync_out (vsync_out), .hblnk_out (hblnk_out), .vblnk_out (vblnk_out),
    .rgb_out (rgb_out), .active (active)
  );

  always #5 pclk = ~pclk;

  // Headstone bitmap: narrow cap, full-width row 6 and base row 31.
  function automatic logic [15:0] rom_row(int r);
    if (r == 0)       return 16'h03C0;
    else if (r < 6)   return 16'h1FF8;
    else if (r == 6)  return 16'hFFFF;
    else if (r < 31)  return 16'h3FFC;
    else              return 16'hFFFF;
  endfunction

  assign rom_pixels = rom_row(int'(rom_addr));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  int m_x, m_y, m_px, m_py, m_age;
  bit m_alive, m_pend, m_prev_vb;

  function automatic bit m_vis();
    if (!m_alive) return 1'b0;
    if (m_age < LIFE - BLINK) return 1'b1;
    return (((m_age - (LIFE - BLINK)) / PERIOD) % 2) == 0;
  endfunction

  function automatic void model_reset();
    m_x = 0; m_y = 0; m_px = 0; m_py = 0; m_age = 0;
    m_alive = 0; m_pend = 0; m_prev_vb = 0;
  endfunction

  function automatic void model_step(bit vb, bit sp, int sx, int sy);
    bit tick;
    tick = vb && !m_prev_vb;
    m_prev_vb = vb;
    if (tick) begin
      if (m_pend) begin
        m_x = m_px; m_y = m_py; m_alive = 1; m_age = 0; m_pend = 0;
      end else if (m_alive) begin
        m_age++;
        if (m_age >= LIFE) m_alive = 0;
      end
    end
    if (sp) begin
      m_px = sx; m_py = sy; m_pend = 1;
    end
  endfunction

  typedef struct packed {
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } pix_t;

  function automatic logic [11:0] model_rgb(pix_t p);
    int dx, dy;
    logic [15:0] row;
    dx = int'(p.h) - m_x;
    dy = int'(p.v) - m_y;
    if (p.hb || p.vb) return 12'h000;
    if (m_vis() && dx >= 0 && dx < 16 && dy >= 0 && dy < 32) begin
      row = rom_row(dy);
      if (row[15 - dx]) return COLOR;
    end
    return p.rgb;
  endfunction

  typedef struct {
    logic [11:0] rgb;
    logic [25:0] tim;
    logic        tchk;
    logic [11:0] texp;
    string       tname;
  } exp_t;

  exp_t hold;

  // One pixel clock: drive at negedge, model the edge, compare just after it.
  task automatic cycle(input pix_t p, input logic sp, input int sx, input int sy,
                       input logic tchk, input logic [11:0] texp, input string tname);
    exp_t cur;
    logic [4:0] addr;
    hcount_in = p.h; vcount_in = p.v; hsync_in = p.hs; vsync_in = p.vs;
    hblnk_in = p.hb; vblnk_in = p.vb; rgb_in = p.rgb;
    spawn = sp; spawn_x = 11'(sx); spawn_y = 11'(sy);
    cur.rgb   = model_rgb(p);
    cur.tim   = {p.h, p.v, p.hs, p.vs, p.hb, p.vb};
    cur.tchk  = tchk;
    cur.texp  = texp;
    cur.tname = tname;
    addr = 5'((int'(p.v) - m_y) & 31);
    @(posedge pclk);
    model_step(p.vb, sp, sx, sy);
    #1;
    check("rgb_model", rgb_out, hold.rgb);
    check("timing_delay", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, hold.tim);
    if (hold.tchk) check(hold.tname, rgb_out, hold.texp);
    check("rom_addr", rom_addr, addr);
    check("active_model", active, m_alive);
    hold = cur;
    @(negedge pclk);
    spawn = 1'b0;
  endtask

  function automatic pix_t mk(int h, int v, logic hb, logic [11:0] rgb);
    pix_t p;
    p.h = 11'(h); p.v = 11'(v);
    p.hs = 1'($urandom_range(0, 1)); p.vs = 1'b0;
    p.hb = hb; p.vb = 1'b0; p.rgb = rgb;
    return p;
  endfunction

  task automatic px(input int h, input int v, input logic [11:0] rgb);
    cycle(mk(h, v, 1'b0, rgb), 1'b0, 0, 0, 1'b0, 12'h0, "");
  endtask

  task automatic pxt(input int h, input int v, input logic hb, input logic [11:0] rgb,
                     input logic [11:0] exp, input string name);
    cycle(mk(h, v, hb, rgb), 1'b0, 0, 0, 1'b1, exp, name);
  endtask

  task automatic spawn_at(input int x, input int y);
    cycle(mk(5, 5, 1'b0, 12'h0), 1'b1, x, y, 1'b0, 12'h0, "");
  endtask

  // Two blanking cycles; the first is the frame tick.
  task automatic vblank(input logic sp = 1'b0, input int sx = 0, input int sy = 0);
    pix_t p;
    p = mk(int'($urandom_range(0, 2047)), 600, 1'b1, 12'(($urandom)));
    p.vb = 1'b1; p.vs = 1'b1;
    cycle(p, sp, sx, sy, 1'b0, 12'h0, "");
    p.vb = 1'b1;
    cycle(p, 1'b0, 0, 0, 1'b0, 12'h0, "");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    spawn = 1'b0;
    #1;
    check("rst_rgb", rgb_out, 12'h000);
    check("rst_timing", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, 26'h0);
    check("rst_rom_addr", rom_addr, 5'd0);
    check("rst_active", active, 1'b0);
    model_reset();
    hold.rgb = '0; hold.tim = '0; hold.tchk = 1'b0; hold.texp = '0; hold.tname = "";
    @(posedge pclk);
    @(negedge pclk);
    rst = 1'b0;
  endtask

  typedef struct {
    int          h, v;
    logic        hb;
    logic [11:0] rgb, exp;
    string       name;
  } vec_t;

  vec_t vec[19];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Headstone at (100,200)
    vec[0]  = '{106, 200, 1'b0, 12'h123, COLOR,   "r0c6_set"};
    vec[1]  = '{100, 200, 1'b0, 12'h456, 12'h456, "r0c0_clear"};
    vec[2]  = '{100, 206, 1'b0, 12'h789, COLOR,   "r6c0_set"};
    vec[3]  = '{115, 206, 1'b0, 12'h111, COLOR,   "r6c15_set"};
    vec[4]  = '{116, 206, 1'b0, 12'h222, 12'h222, "right_of_win"};
    vec[5]  = '{99,  206, 1'b0, 12'h333, 12'h333, "left_of_win"};
    vec[6]  = '{100, 231, 1'b0, 12'h444, COLOR,   "r31_set"};
    vec[7]  = '{100, 232, 1'b0, 12'h555, 12'h555, "below_win"};
    vec[8]  = '{100, 199, 1'b0, 12'h666, 12'h666, "above_win"};
    vec[9]  = '{100, 206, 1'b1, 12'h777, 12'h000, "hblank_black"};
    // Headstone at (2040,2030)
    vec[10] = '{2046, 2030, 1'b0, 12'h0a0, COLOR,   "edge_r0c6"};
    vec[11] = '{2040, 2036, 1'b0, 12'h0a1, COLOR,   "edge_r6c0"};
    vec[12] = '{2047, 2036, 1'b0, 12'h0a2, COLOR,   "edge_r6c7"};
    vec[13] = '{0,    2036, 1'b0, 12'h0a3, 12'h0a3, "edge_nowrap_h"};
    vec[14] = '{2039, 2036, 1'b0, 12'h0a4, 12'h0a4, "edge_left"};
    vec[15] = '{2040, 2029, 1'b0, 12'h0a5, 12'h0a5, "edge_above"};
    vec[16] = '{2040, 0,    1'b0, 12'h0a6, 12'h0a6, "edge_nowrap_v"};
    vec[17] = '{2047, 2047, 1'b0, 12'h0a7, COLOR,   "edge_r17c7"};
    vec[18] = '{2040, 2036, 1'b1, 12'h0a8, 12'h000, "edge_hblank"};

    @(negedge pclk);
    do_reset();

    // Spawn mid-frame: nothing changes before the tick.
    px(50, 190, 12'h010);
    spawn_at(100, 200);
    pxt(106, 200, 1'b0, 12'h321, 12'h321, "pre_tick_hidden");
    vblank();
    check("spawn_active", active, 1'b1);
    for (int i = 0; i < 10; i++) pxt(vec[i].h, vec[i].v, vec[i].hb, vec[i].rgb, vec[i].exp, vec[i].name);

    // Lifetime: frames 1..8 on, 9..10 blinked off, frame 11 dead.
    for (int f = 1; f <= 11; f++) begin
      pxt(106, 200, 1'b0, 12'h0a5, (f <= 8) ? COLOR : 12'h0a5, "life_pattern");
      vblank();
      check("life_active", active, f < 10);
    end

    // Two spawns before one tick: last wins.
    spawn_at(10, 10);
    px(20, 20, 12'h001);
    spawn_at(300, 50);
    vblank();
    pxt(16, 10, 1'b0, 12'h0f0, 12'h0f0, "first_spawn_dropped");
    pxt(306, 50, 1'b0, 12'h0f0, COLOR, "last_spawn_wins");

    // Spawn coinciding with the tick appears one frame late.
    do_reset();
    px(1, 1, 12'h002);
    vblank(1'b1, 500, 400);
    check("tick_spawn_late", active, 1'b0);
    pxt(506, 400, 1'b0, 12'h0e0, 12'h0e0, "tick_spawn_hidden");
    vblank();
    check("tick_spawn_next", active, 1'b1);
    pxt(506, 400, 1'b0, 12'h0e0, COLOR, "tick_spawn_shown");

    // Bottom-right corner: no wrap.
    spawn_at(2040, 2030);
    vblank();
    for (int i = 10; i < 19; i++) pxt(vec[i].h, vec[i].v, vec[i].hb, vec[i].rgb, vec[i].exp, vec[i].name);
    vblank();

    // Reset in the middle of BLINK.
    spawn_at(600, 300);
    vblank();
    for (int t = 0; t < 7; t++) vblank();
    check("blink_reached", active, 1'b1);
    pxt(606, 300, 1'b0, 12'h0c0, COLOR, "blink_on");
    spawn_at(700, 700);
    do_reset();
    pxt(606, 300, 1'b0, 12'h0c1, 12'h0c1, "post_reset_pass");
    vblank();
    check("post_reset_idle", active, 1'b0);
    pxt(606, 300, 1'b0, 12'h0c2, 12'h0c2, "post_reset_frame2");
    pxt(700, 700, 1'b0, 12'h0c3, 12'h0c3, "pending_discarded");

    // Randomized frames against the model.
    for (int fr = 0; fr < 40; fr++) begin
      int n;
      n = int'($urandom_range(8, 30));
      for (int i = 0; i < n; i++) begin
        int h, v, sx, sy;
        logic sp;
        if ($urandom_range(0, 1) == 1) begin
          h = m_x + int'($urandom_range(0, 21)) - 3;
          v = m_y + int'($urandom_range(0, 37)) - 3;
        end else begin
          h = int'($urandom_range(0, 2047));
          v = int'($urandom_range(0, 2047));
        end
        if (h < 0) h = 0;
        if (h > 2047) h = 2047;
        if (v < 0) v = 0;
        if (v > 2047) v = 2047;
        sp = ($urandom_range(0, 19) == 0);
        sx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2030, 2047)) : int'($urandom_range(0, 2047));
        sy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2015, 2047)) : int'($urandom_range(0, 2047));
        cycle(mk(h, v, ($urandom_range(0, 7) == 0), 12'($urandom)), sp, sx, sy, 1'b0, 12'h0, "");
      end
      if ($urandom_range(0, 5) == 0)
        vblank(1'b1, int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
      else
        vblank();
    end

    px(0, 0, 12'h000);
    px(0, 0, 12'h000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
